// File: rtl/timer_scheduler.sv
// Shared one-shot timer: round-robin arbitration of NUM_REQ requesters onto one
// prescaled down-counter, with single-cycle grant and completion pulses.
module timer_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int CNT_W   = 16,
    parameter int PRESC_W = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic [NUM_REQ*CNT_W-1:0]   load_i,
    input  logic [PRESC_W-1:0]         presc_i,
    output logic [NUM_REQ-1:0]         gnt_o,
    output logic [NUM_REQ-1:0]         done_o,
    output logic                       busy_o,
    output logic [$clog2(NUM_REQ)-1:0] owner_o,
    output logic [CNT_W-1:0]           cnt_o,
    output logic [1:0]                 state_o
);
    localparam int IDX_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     owner_q, owner_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [PRESC_W-1:0]   presc_lat_q, presc_lat_d;
    logic [PRESC_W-1:0]   presc_cnt_q, presc_cnt_d;
    logic [NUM_REQ-1:0]   armed_q, armed_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic [NUM_REQ-1:0]   done_q, done_d;

    logic [NUM_REQ-1:0]   eligible;
    logic                 found;
    logic [IDX_W-1:0]     win;

    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] idx);
        return (int'(idx) == NUM_REQ - 1) ? '0 : idx + 1'b1;
    endfunction

    assign eligible = req_i & armed_q;

    // First eligible requester at or after ptr, wrapping modulo NUM_REQ.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && eligible[(int'(ptr_q) + i) % NUM_REQ]) begin
                found = 1'b1;
                win   = IDX_W'((int'(ptr_q) + i) % NUM_REQ);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        presc_lat_d = presc_lat_q;
        presc_cnt_d = presc_cnt_q;
        gnt_d       = '0;
        done_d      = '0;
        // A requester re-arms whenever it is seen low; completion or abort clears it.
        armed_d     = armed_q | ~req_i;

        case (state_q)
            S_IDLE: begin
                if (found) begin
                    owner_d     = win;
                    cnt_d       = load_i[int'(win)*CNT_W +: CNT_W];
                    presc_lat_d = presc_i;
                    presc_cnt_d = '0;
                    gnt_d[win]  = 1'b1;
                    state_d     = S_RUN;
                end
            end
            S_RUN: begin
                if (!req_i[owner_q]) begin
                    armed_d[owner_q] = 1'b0;
                    ptr_d            = wrap_inc(owner_q);
                    state_d          = S_IDLE;
                end else if (cnt_q == '0) begin
                    done_d[owner_q]  = 1'b1;
                    armed_d[owner_q] = 1'b0;
                    state_d          = S_DONE;
                end else if (presc_cnt_q == presc_lat_q) begin
                    presc_cnt_d = '0;
                    cnt_d       = cnt_q - 1'b1;
                end else begin
                    presc_cnt_d = presc_cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                ptr_d   = wrap_inc(owner_q);
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            owner_q     <= '0;
            ptr_q       <= '0;
            cnt_q       <= '0;
            presc_lat_q <= '0;
            presc_cnt_q <= '0;
            armed_q     <= '1;
            gnt_q       <= '0;
            done_q      <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            presc_lat_q <= presc_lat_d;
            presc_cnt_q <= presc_cnt_d;
            armed_q     <= armed_d;
            gnt_q       <= gnt_d;
            done_q      <= done_d;
        end
    end

    assign gnt_o   = gnt_q;
    assign done_o  = done_q;
    assign busy_o  = (state_q != S_IDLE);
    assign owner_o = owner_q;
    assign cnt_o   = cnt_q;
    assign state_o = state_q;
endmodule

// File: tb/tb_timer_scheduler.sv
// Directed bench for timer_scheduler: grant/done events are predicted into a
// queue as stimulus is driven and compared with their cycle gaps as they occur.
module tb_timer_scheduler;
    localparam int NUM_REQ = 4;
    localparam int CNT_W   = 16;
    localparam int PRESC_W = 8;
    localparam int IDX_W   = 2;
    localparam int GAP_W   = 20;
    localparam int EV_W    = 1 + NUM_REQ + GAP_W;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NUM_REQ-1:0]       req_i;
    logic [NUM_REQ*CNT_W-1:0] load_i;
    logic [PRESC_W-1:0]       presc_i;
    logic [NUM_REQ-1:0]       gnt_o;
    logic [NUM_REQ-1:0]       done_o;
    logic                     busy_o;
    logic [IDX_W-1:0]         owner_o;
    logic [CNT_W-1:0]         cnt_o;
    logic [1:0]               state_o;

    int checks = 0;
    int errors = 0;

    // Event word: {is_done, one-hot vector, cycles since the previous event/step}
    logic [EV_W-1:0]  exp_q[$];
    logic [CNT_W-1:0] cnt_exp_q[$];

    timer_scheduler #(
        .NUM_REQ(NUM_REQ),
        .CNT_W  (CNT_W),
        .PRESC_W(PRESC_W)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .req_i  (req_i),
        .load_i (load_i),
        .presc_i(presc_i),
        .gnt_o  (gnt_o),
        .done_o (done_o),
        .busy_o (busy_o),
        .owner_o(owner_o),
        .cnt_o  (cnt_o),
        .state_o(state_o)
    );

    always #5 clk = ~clk;

    // Pulses are one-hot and grant/done never coincide.
    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            assert ($onehot0({gnt_o, done_o})) else begin
                errors++;
                $error("FAIL pulse_onehot: observed gnt=%b done=%b expected at most one bit", gnt_o, done_o);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push_ev(input logic kind, input logic [NUM_REQ-1:0] vec, input int gap);
        exp_q.push_back({kind, vec, GAP_W'(gap)});
    endtask

    task automatic expect_event(input string tag, input int budget);
        int              gap = 0;
        bit              found = 1'b0;
        logic [EV_W-1:0] obs;
        logic [EV_W-1:0] exp;
        while (!found && gap < budget) begin
            tick();
            gap++;
            if (gnt_o != '0 || done_o != '0) found = 1'b1;
        end
        obs = {done_o != '0, gnt_o | done_o, GAP_W'(gap)};
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed done=%0b vec=%b gap=%0d expected done=%0b vec=%b gap=%0d",
                   tag, obs[EV_W-1], obs[GAP_W +: NUM_REQ], obs[GAP_W-1:0],
                   exp[EV_W-1], exp[GAP_W +: NUM_REQ], exp[GAP_W-1:0]);
        end
    endtask

    // One isolated timeout on requester k; optionally disturb load/presc mid-run.
    task automatic run_timeout(input int k, input int ld, input int pr, input bit perturb);
        load_i[k*CNT_W +: CNT_W] = CNT_W'(ld);
        presc_i = PRESC_W'(pr);
        req_i = NUM_REQ'(1) << k;
        push_ev(1'b0, NUM_REQ'(1) << k, 1);
        expect_event("grant", 4);
        check_val("owner", 32'(owner_o), 32'(k));
        check_val("busy_run", 32'(busy_o), 1);
        check_val("cnt_at_grant", 32'(cnt_o), 32'(ld));
        for (int t = 1; t <= ld * (pr + 1); t++) begin
            cnt_exp_q.push_back(CNT_W'(ld - t / (pr + 1)));
            tick();
            if (perturb && t == 2) begin
                load_i[k*CNT_W +: CNT_W] = CNT_W'(ld + 7);
                presc_i = PRESC_W'(pr + 3);
            end
            check_val("cnt_trace", 32'(cnt_o), 32'(cnt_exp_q.pop_front()));
        end
        push_ev(1'b1, NUM_REQ'(1) << k, 1);
        expect_event("done", 4);
        check_val("cnt_at_done", 32'(cnt_o), 0);
        req_i = '0;
        tick();
        check_val("busy_after_done", 32'(busy_o), 0);
    endtask

    initial begin
        rst = 1'b1;
        req_i = '0;
        load_i = '0;
        presc_i = '0;
        repeat (3) tick();
        check_val("rst_gnt", 32'(gnt_o), 0);
        check_val("rst_done", 32'(done_o), 0);
        check_val("rst_busy", 32'(busy_o), 0);
        check_val("rst_owner", 32'(owner_o), 0);
        check_val("rst_cnt", 32'(cnt_o), 0);
        rst = 1'b0;

        // Single requester, prescaled run with mid-run input changes, load=0, max load.
        run_timeout(2, 5, 0, 1'b0);
        run_timeout(2, 3, 2, 1'b1);
        run_timeout(0, 0, 0, 1'b0);
        run_timeout(1, 65535, 0, 1'b1);

        // Reset in the middle of a run at cnt=3.
        load_i[3*CNT_W +: CNT_W] = CNT_W'(10);
        presc_i = '0;
        req_i = 4'b1000;
        push_ev(1'b0, 4'b1000, 1);
        expect_event("grant_pre_rst", 4);
        repeat (7) tick();
        check_val("cnt_before_rst", 32'(cnt_o), 3);
        rst = 1'b1;
        tick();
        check_val("midrst_gnt", 32'(gnt_o), 0);
        check_val("midrst_done", 32'(done_o), 0);
        check_val("midrst_busy", 32'(busy_o), 0);
        check_val("midrst_owner", 32'(owner_o), 0);
        check_val("midrst_cnt", 32'(cnt_o), 0);

        // Contention: all four held high, served 0..3 once each.
        rst = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) load_i[k*CNT_W +: CNT_W] = CNT_W'(1);
        req_i = 4'b1111;
        for (int k = 0; k < NUM_REQ; k++) begin
            push_ev(1'b0, NUM_REQ'(1) << k, (k == 0) ? 1 : 2);
            push_ev(1'b1, NUM_REQ'(1) << k, 2);
        end
        for (int e = 0; e < 2 * NUM_REQ; e++) expect_event("contention", 8);
        repeat (8) begin
            tick();
            check_val("starve_gnt", 32'(gnt_o), 0);
            check_val("starve_busy", 32'(busy_o), 0);
        end
        req_i = 4'b1110;
        tick();
        req_i = 4'b1111;
        push_ev(1'b0, 4'b0001, 1);
        push_ev(1'b1, 4'b0001, 2);
        expect_event("rearm_grant", 4);
        expect_event("rearm_done", 4);
        req_i = '0;
        tick();

        // Abort: owner 1 drops at cnt=7, pending requester 2 goes next.
        load_i[1*CNT_W +: CNT_W] = CNT_W'(10);
        load_i[2*CNT_W +: CNT_W] = CNT_W'(2);
        req_i = 4'b0110;
        push_ev(1'b0, 4'b0010, 1);
        expect_event("abort_grant", 4);
        repeat (3) begin
            tick();
            check_val("abort_run_done", 32'(done_o), 0);
        end
        check_val("cnt_before_abort", 32'(cnt_o), 7);
        req_i = 4'b0100;
        tick();
        check_val("abort_busy", 32'(busy_o), 0);
        check_val("abort_done", 32'(done_o), 0);
        check_val("abort_gnt", 32'(gnt_o), 0);
        push_ev(1'b0, 4'b0100, 1);
        push_ev(1'b1, 4'b0100, 3);
        expect_event("after_abort_grant", 4);
        expect_event("after_abort_done", 6);
        req_i = '0;
        tick();

        check_val("queue_empty", 32'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
